// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared state encoding, key codes and sizing helper for the code lock
package lock_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_CHECK,
    S_OPEN,
    S_PROG,
    S_LOCKOUT
  } state_e;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  // One timer serves both windows, so it is sized for the longer one (never below 1 bit).
  function automatic int timer_width(input int a, input int b);
    int m;
    int w;
    m = (a > b) ? a : b;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// rtl/lock_timer.sv - loadable down-counter that parks at zero and flags expiry
module lock_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value   = cnt_q;
  assign expired = (cnt_q == '0);

endmodule

// File: rtl/code_lock_ctrl.sv
// rtl/code_lock_ctrl.sv - keypad code-lock sequencer: entry, compare, unlock window,
// failed-attempt lockout and code reprogramming
module code_lock_ctrl
  import lock_pkg::*;
#(
  parameter int                  CODE_LEN       = 4,
  parameter int                  MAX_TRIES      = 3,
  parameter int                  UNLOCK_CYCLES  = 1000,
  parameter int                  LOCKOUT_CYCLES = 10000,
  parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE = 16'h1234
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] KEY_N,
  input  logic       KEY_V,
  output logic       UNLOCK,
  output logic       ALARM,
  output logic       PROG_MODE,
  output logic       ERR,
  output logic       DONE,
  output logic [3:0] FAIL_CNT
);

  localparam int BUF_W = 4 * CODE_LEN;
  localparam int TMR_W = timer_width(UNLOCK_CYCLES, LOCKOUT_CYCLES);

  state_e             state_q, state_d;
  logic               key_v_q;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [BUF_W-1:0]   code_q, code_d;
  logic [3:0]         fail_q, fail_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               unlock_q, unlock_d;
  logic               alarm_q, alarm_d;
  logic               prog_q, prog_d;

  logic               press, is_digit, is_star, is_hash;
  logic               store, clear;
  logic               full_entry, match;
  logic [3:0]         fail_inc;
  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_val;
  logic [TMR_W-1:0]   tmr_value;
  logic               tmr_expired;

  assign press    = KEY_V & ~key_v_q;
  assign is_digit = press & (KEY_N <= 4'd9);
  assign is_star  = press & (KEY_N == KEY_STAR);
  assign is_hash  = press & (KEY_N == KEY_HASH);

  assign full_entry = (cnt_q == 4'(CODE_LEN)) & ~ovf_q;
  assign match      = full_entry & (buf_q == code_q);
  assign fail_inc   = (fail_q >= 4'(MAX_TRIES)) ? 4'(MAX_TRIES) : fail_q + 4'd1;

  lock_timer #(.W(TMR_W)) u_timer (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (tmr_load),
    .load_val (tmr_val),
    .value    (tmr_value),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    fail_d   = fail_q;
    err_d    = 1'b0;
    done_d   = 1'b0;
    store    = 1'b0;
    clear    = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;

    case (state_q)
      S_IDLE: begin
        if (is_digit) begin
          store   = 1'b1;
          state_d = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (is_digit) begin
          store = 1'b1;
        end else if (is_star) begin
          clear   = 1'b1;
          state_d = S_IDLE;
        end else if (is_hash) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        clear = 1'b1;
        if (match) begin
          fail_d   = 4'd0;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(UNLOCK_CYCLES - 1);
          state_d  = S_OPEN;
        end else begin
          err_d  = 1'b1;
          fail_d = fail_inc;
          if (fail_inc == 4'(MAX_TRIES)) begin
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(LOCKOUT_CYCLES - 1);
            state_d  = S_LOCKOUT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_OPEN: begin
        // Expiry outranks a simultaneous keypress; the key is simply lost.
        if (tmr_expired || is_hash) begin
          state_d = S_IDLE;
        end else if (is_star) begin
          clear   = 1'b1;
          state_d = S_PROG;
        end
      end
      S_PROG: begin
        if (is_digit) begin
          store = 1'b1;
        end else if (is_hash) begin
          clear   = 1'b1;
          state_d = S_IDLE;
          if (full_entry) begin
            code_d = buf_q;
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (is_star) begin
          clear   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_LOCKOUT: begin
        if (tmr_expired) begin
          fail_d  = 4'd0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Entry buffer: digits shift in from the right so digit 0 ends up in the MSBs.
  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clear) begin
      buf_d = '0;
      cnt_d = 4'd0;
      ovf_d = 1'b0;
    end else if (store) begin
      if (cnt_q < 4'(CODE_LEN)) begin
        buf_d = (buf_q << 4) | BUF_W'(KEY_N);
        cnt_d = cnt_q + 4'd1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_comb begin
    unlock_d = (state_d == S_OPEN);
    alarm_d  = (state_d == S_LOCKOUT);
    prog_d   = (state_d == S_PROG);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      key_v_q  <= 1'b0;
      buf_q    <= '0;
      cnt_q    <= 4'd0;
      ovf_q    <= 1'b0;
      code_q   <= DEFAULT_CODE;
      fail_q   <= 4'd0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      unlock_q <= 1'b0;
      alarm_q  <= 1'b0;
      prog_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      key_v_q  <= KEY_V;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      code_q   <= code_d;
      fail_q   <= fail_d;
      err_q    <= err_d;
      done_q   <= done_d;
      unlock_q <= unlock_d;
      alarm_q  <= alarm_d;
      prog_q   <= prog_d;
    end
  end

  assign UNLOCK    = unlock_q;
  assign ALARM     = alarm_q;
  assign PROG_MODE = prog_q;
  assign ERR       = err_q;
  assign DONE      = done_q;
  assign FAIL_CNT  = fail_q;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// tb/tb_code_lock_ctrl.sv - directed self-checking bench for code_lock_ctrl
module tb_code_lock_ctrl;

  localparam int UNLOCK_CYCLES  = 20;
  localparam int LOCKOUT_CYCLES = 50;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [3:0] KEY_N = 4'd0;
  logic       KEY_V = 1'b0;
  logic       UNLOCK, ALARM, PROG_MODE, ERR, DONE;
  logic [3:0] FAIL_CNT;

  int n_checks = 0;
  int n_errors = 0;
  int win;

  code_lock_ctrl #(
    .CODE_LEN       (4),
    .MAX_TRIES      (3),
    .UNLOCK_CYCLES  (UNLOCK_CYCLES),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
    .DEFAULT_CODE   (16'h1234)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .KEY_N     (KEY_N),
    .KEY_V     (KEY_V),
    .UNLOCK    (UNLOCK),
    .ALARM     (ALARM),
    .PROG_MODE (PROG_MODE),
    .ERR       (ERR),
    .DONE      (DONE),
    .FAIL_CNT  (FAIL_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One keypress: KEY_V high across one rising edge, returns just after that edge.
  task automatic press(input logic [3:0] k);
    @(negedge CLK);
    KEY_N = k;
    KEY_V = 1'b1;
    @(negedge CLK);
    KEY_V = 1'b0;
  endtask

  // Presses n keys packed in nibbles, first key in the most significant used nibble.
  task automatic enter(input logic [31:0] keys, input int n);
    logic [31:0] kv;
    kv = keys;
    for (int i = 0; i < n; i++) begin
      press(kv[4*(n-1-i) +: 4]);
    end
  endtask

  // Counts consecutive sampled cycles of UNLOCK (or ALARM) starting now.
  // During ALARM it keeps hammering digit presses; with inject it presses '*' in the last UNLOCK cycle.
  task automatic window(input bit alarm_sel, input bit inject, output int n);
    n = 0;
    while (((alarm_sel ? ALARM : UNLOCK) === 1'b1) && n < 200) begin
      n++;
      if (alarm_sel) begin
        KEY_N = 4'd1;
        KEY_V = n[0];
      end else if (inject && n == UNLOCK_CYCLES) begin
        KEY_N = 4'd10;
        KEY_V = 1'b1;
      end
      @(negedge CLK);
    end
    KEY_V = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    check("rst_unlock", UNLOCK, 0);
    check("rst_alarm", ALARM, 0);
    check("rst_prog", PROG_MODE, 0);
    check("rst_err", ERR, 0);
    check("rst_done", DONE, 0);
    check("rst_fail", FAIL_CNT, 0);
    RST_N = 1'b1;

    // Correct code with an invalid key mixed in.
    enter(32'h12D34B, 6);
    check("chk_cycle_unlock", UNLOCK, 0);
    @(negedge CLK);
    check("ok_unlock", UNLOCK, 1);
    check("ok_err", ERR, 0);
    check("ok_fail", FAIL_CNT, 0);
    window(1'b0, 1'b0, win);
    check("unlock_len", win, UNLOCK_CYCLES);

    // Three wrong entries lead into lockout.
    for (int i = 1; i <= 3; i++) begin
      enter(32'h1235B, 5);
      @(negedge CLK);
      check("wrong_err", ERR, 1);
      check("wrong_fail", FAIL_CNT, i);
      check("wrong_unlock", UNLOCK, 0);
      if (i < 3) begin
        @(negedge CLK);
        check("err_one_cycle", ERR, 0);
        check("no_alarm_yet", ALARM, 0);
      end
    end
    check("alarm_on", ALARM, 1);
    window(1'b1, 1'b0, win);
    check("alarm_len", win, LOCKOUT_CYCLES);
    check("fail_cleared", FAIL_CNT, 0);
    enter(32'h1234B, 5);
    @(negedge CLK);
    check("post_lockout_unlock", UNLOCK, 1);
    press(4'd11);
    check("hash_relock", UNLOCK, 0);

    // Length errors, then '*' clears a partial entry.
    enter(32'h123B, 4);
    @(negedge CLK);
    check("short_err", ERR, 1);
    check("short_fail", FAIL_CNT, 1);
    enter(32'h12345B, 6);
    @(negedge CLK);
    check("long_err", ERR, 1);
    check("long_fail", FAIL_CNT, 2);
    enter(32'h12A1234B, 8);
    @(negedge CLK);
    check("clear_unlock", UNLOCK, 1);
    check("clear_fail", FAIL_CNT, 0);
    press(4'd11);

    // Held key counts once.
    @(negedge CLK);
    KEY_N = 4'd1;
    KEY_V = 1'b1;
    repeat (10) @(negedge CLK);
    KEY_V = 1'b0;
    enter(32'h234B, 4);
    @(negedge CLK);
    check("held_unlock", UNLOCK, 1);
    check("held_err", ERR, 0);
    press(4'd11);

    // Reprogram to 9876.
    enter(32'h1234B, 5);
    @(negedge CLK);
    check("prog_pre_unlock", UNLOCK, 1);
    press(4'd10);
    check("prog_mode", PROG_MODE, 1);
    check("prog_unlock_drop", UNLOCK, 0);
    enter(32'h9876B, 5);
    check("prog_done", DONE, 1);
    check("prog_mode_exit", PROG_MODE, 0);
    @(negedge CLK);
    check("done_one_cycle", DONE, 0);
    enter(32'h1234B, 5);
    @(negedge CLK);
    check("old_code_err", ERR, 1);
    check("old_code_fail", FAIL_CNT, 1);
    enter(32'h9876B, 5);
    @(negedge CLK);
    check("new_code_unlock", UNLOCK, 1);

    // Asynchronous reset while open.
    #2 RST_N = 1'b0;
    #1 check("async_rst_unlock", UNLOCK, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    enter(32'h9876B, 5);
    @(negedge CLK);
    check("reverted_err", ERR, 1);
    check("reverted_fail", FAIL_CNT, 1);
    enter(32'h1234B, 5);
    @(negedge CLK);
    check("reverted_unlock", UNLOCK, 1);
    check("reverted_fail0", FAIL_CNT, 0);
    window(1'b0, 1'b1, win);
    check("expiry_len", win, UNLOCK_CYCLES);
    check("expiry_key_dropped", PROG_MODE, 0);

    // Asynchronous reset during lockout.
    for (int i = 1; i <= 3; i++) begin
      enter(32'h1235B, 5);
      @(negedge CLK);
    end
    repeat (5) @(negedge CLK);
    check("lock_alarm", ALARM, 1);
    check("lock_fail", FAIL_CNT, 3);
    #2 RST_N = 1'b0;
    #1 check("async_rst_alarm", ALARM, 0);
    check("async_rst_fail", FAIL_CNT, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    enter(32'h1234B, 5);
    @(negedge CLK);
    check("after_rst_unlock", UNLOCK, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
